// File: rtl/answer_judge.sv
// Local answer checker: validates a submitted factor against the current question
// with a sequential restoring remainder and merges the result with the opponent's solve pulse.
module answer_judge (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] STATE,
    input  logic [7:0] Q,
    input  logic [7:0] ANS,
    input  logic       SUBMIT,
    input  logic       OPP_OK,
    output logic [1:0] JUDG_OUT,
    output logic [1:0] WRONG_OUT,
    output logic       BUSY,
    output logic [3:0] MISS_CNT
);

    localparam logic [3:0] ST_READY    = 4'b0010;
    localparam logic [3:0] ST_QUESTION = 4'b0011;
    localparam logic [3:0] ST_INPUT    = 4'b0100;
    localparam logic [3:0] ST_WRONG    = 4'b0111;

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_VERD} fsm_t;

    fsm_t       fsm, nxt;
    logic [7:0] a, q;
    logic [8:0] r, r_sh, r_nx;
    logic [2:0] k;
    logic       triv, wrong;
    logic       accept, abort, do_verd, opp_hit;
    logic [1:0] judg_nx, wrong_nx;
    logic [3:0] miss_nx;

    assign accept  = (fsm == S_IDLE) && SUBMIT && (STATE == ST_INPUT) && (WRONG_OUT != 2'b01);
    assign abort   = (STATE == ST_READY) || ((STATE == ST_QUESTION) && (fsm != S_IDLE));
    assign do_verd = (fsm == S_VERD) && !abort;
    assign opp_hit = OPP_OK && ((STATE == ST_QUESTION) || (STATE == ST_INPUT));

    // One restoring-remainder step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        r_sh = {r[7:0], q[k]};
        r_nx = (r_sh >= {1'b0, a}) ? (r_sh - {1'b0, a}) : r_sh;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fsm       <= S_IDLE;
            BUSY      <= 1'b0;
            JUDG_OUT  <= 2'b00;
            WRONG_OUT <= 2'b00;
            MISS_CNT  <= 4'd0;
        end else begin
            fsm       <= nxt;
            BUSY      <= (nxt != S_IDLE);
            JUDG_OUT  <= judg_nx;
            WRONG_OUT <= wrong_nx;
            MISS_CNT  <= miss_nx;
        end
    end

    always_comb begin
        nxt = fsm;
        case (fsm)
            S_IDLE: if (accept) nxt = S_DIV;
            S_DIV:  if (triv || (k == 3'd0)) nxt = S_VERD;
            S_VERD: nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
        if (abort) nxt = S_IDLE;
    end

    always_comb begin
        judg_nx  = JUDG_OUT;
        wrong_nx = WRONG_OUT;
        miss_nx  = MISS_CNT;
        if (opp_hit && (JUDG_OUT == 2'b00)) judg_nx = 2'b10;
        // Drop a stale wrong verdict so returning to INPUT doesn't re-trigger WRONG.
        if ((STATE == ST_WRONG) && (WRONG_OUT == 2'b11)) wrong_nx = 2'b00;
        if (do_verd) begin
            if (wrong) begin
                wrong_nx = 2'b11;
                if (MISS_CNT != 4'd15) miss_nx = MISS_CNT + 4'd1;
            end else begin
                wrong_nx = 2'b01;
                if (JUDG_OUT == 2'b00) judg_nx = opp_hit ? 2'b11 : 2'b01;
            end
        end
        if (STATE == ST_READY) begin
            judg_nx  = 2'b00;
            wrong_nx = 2'b00;
            miss_nx  = 4'd0;
        end
    end

    // Trivial rejects are flagged at capture and resolved on the first DIV cycle,
    // so both paths share the same state sequence.
    always_ff @(posedge CLK) begin
        if (RST) begin
            a     <= 8'd0;
            q     <= 8'd0;
            r     <= 9'd0;
            k     <= 3'd0;
            triv  <= 1'b0;
            wrong <= 1'b0;
        end else if (accept) begin
            a    <= ANS;
            q    <= Q;
            r    <= 9'd0;
            k    <= 3'd7;
            triv <= (ANS < 8'd2) || (ANS >= Q);
        end else if (fsm == S_DIV) begin
            if (triv) begin
                wrong <= 1'b1;
            end else begin
                r <= r_nx;
                k <= k - 3'd1;
                if (k == 3'd0) wrong <= (r_nx != 9'd0);
            end
        end
    end

endmodule

// File: tb/tb_answer_judge.sv
// Scoreboard bench for answer_judge: stimulus queues expected verdicts, a monitor
// compares them each time BUSY drops.
module tb_answer_judge;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] STATE;
    logic [7:0] Q, ANS;
    logic       SUBMIT, OPP_OK;
    logic [1:0] JUDG_OUT, WRONG_OUT;
    logic       BUSY;
    logic [3:0] MISS_CNT;

    localparam logic [3:0] READY = 4'b0010, QUESTION = 4'b0011, INPUT = 4'b0100, WRONG = 4'b0111;

    typedef struct {
        logic [1:0] j;
        logic [1:0] w;
        logic [3:0] m;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    answer_judge dut (
        .CLK(CLK), .RST(RST), .STATE(STATE), .Q(Q), .ANS(ANS), .SUBMIT(SUBMIT),
        .OPP_OK(OPP_OK), .JUDG_OUT(JUDG_OUT), .WRONG_OUT(WRONG_OUT), .BUSY(BUSY),
        .MISS_CNT(MISS_CNT)
    );

    always #10 CLK = ~CLK;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic expect_v(input logic [1:0] j, input logic [1:0] w, input logic [3:0] m, input int cyc);
        exp_t e;
        e.j = j; e.w = w; e.m = m; e.cyc = cyc;
        sb.push_back(e);
    endtask

    // Submit, then run 12 more edges. Loop index e is the edge about to be awaited.
    task automatic submit(input logic [7:0] ans, input bit opp9, input int abort_at,
                          input logic [3:0] abort_st, input bit dup);
        @(posedge CLK); #1;
        ANS = ans; SUBMIT = 1'b1;
        @(posedge CLK); #1;
        SUBMIT = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            if (opp9 && e == 9) OPP_OK = 1'b1;
            if (dup && e == 2) SUBMIT = 1'b1;
            @(posedge CLK); #1;
            OPP_OK = 1'b0;
            SUBMIT = 1'b0;
            if (abort_at == e) STATE = abort_st;
        end
    endtask

    task automatic new_round(input logic [7:0] qv);
        STATE = READY;
        @(posedge CLK); #1;
        Q = qv;
        STATE = QUESTION;
        @(posedge CLK); #1;
        STATE = INPUT;
    endtask

    // Monitor: BUSY falling ends a check; compare duration and outputs.
    initial begin
        int cyc;
        exp_t e;
        cyc = 0;
        forever begin
            @(negedge CLK);
            if (RST) cyc = 0;
            else if (BUSY) cyc++;
            else if (cyc != 0) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_verdict: got busy for %0d cycles, required none", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("busy_cycles", cyc, e.cyc);
                    chk("judg_out", JUDG_OUT, e.j);
                    chk("wrong_out", WRONG_OUT, e.w);
                    chk("miss_cnt", MISS_CNT, e.m);
                end
                cyc = 0;
            end
        end
    end

    initial begin
        RST = 1'b1; STATE = READY; Q = 8'd0; ANS = 8'd0; SUBMIT = 1'b0; OPP_OK = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_judg", JUDG_OUT, 0);
        chk("rst_wrong", WRONG_OUT, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_miss", MISS_CNT, 0);
        RST = 1'b0;

        // Round 1: Q=91=7*13
        new_round(8'd91);
        expect_v(2'b00, 2'b11, 4'd1, 9);
        submit(8'd5, 0, 0, INPUT, 0);
        STATE = WRONG;
        @(posedge CLK); #1;
        chk("wrong_clear", WRONG_OUT, 0);
        chk("miss_kept", MISS_CNT, 1);
        STATE = INPUT;
        expect_v(2'b00, 2'b11, 4'd2, 2);
        submit(8'd1, 0, 0, INPUT, 0);
        expect_v(2'b00, 2'b11, 4'd3, 2);
        submit(8'd91, 0, 0, INPUT, 0);
        expect_v(2'b00, 2'b11, 4'd4, 2);
        submit(8'd0, 0, 0, INPUT, 0);
        expect_v(2'b01, 2'b01, 4'd4, 9);
        submit(8'd7, 0, 0, INPUT, 0);
        submit(8'd5, 0, 0, INPUT, 0);  // already correct: ignored
        chk("post_correct_wrong", WRONG_OUT, 1);
        chk("post_correct_miss", MISS_CNT, 4);

        // READY clears everything; OPP_OK outside QUESTION/INPUT ignored
        STATE = READY; OPP_OK = 1'b1;
        @(posedge CLK); #1;
        OPP_OK = 1'b0;
        chk("ready_judg", JUDG_OUT, 0);
        chk("ready_wrong", WRONG_OUT, 0);
        chk("ready_miss", MISS_CNT, 0);

        // Round 2: opponent first
        new_round(8'd91);
        OPP_OK = 1'b1;
        @(posedge CLK); #1;
        OPP_OK = 1'b0;
        chk("opp_latch", JUDG_OUT, 2);
        expect_v(2'b10, 2'b01, 4'd0, 9);
        submit(8'd13, 0, 0, INPUT, 0);

        // Round 3: simultaneous solve on the verdict edge
        new_round(8'd221);
        expect_v(2'b11, 2'b01, 4'd0, 9);
        submit(8'd17, 1, 0, INPUT, 0);

        // Round 4: dropped duplicate submit, then READY abort mid-division
        new_round(8'd91);
        expect_v(2'b00, 2'b11, 4'd1, 9);
        submit(8'd5, 0, 0, INPUT, 1);
        expect_v(2'b00, 2'b00, 4'd0, 5);
        submit(8'd7, 0, 4, READY, 0);
        chk("abort_wrong", WRONG_OUT, 0);
        chk("abort_judg", JUDG_OUT, 0);
        chk("abort_busy", BUSY, 0);

        // Round 5: saturation, then QUESTION abort keeps the count
        new_round(8'd91);
        for (int i = 0; i < 16; i++) begin
            expect_v(2'b00, 2'b11, (i < 15) ? 4'(i + 1) : 4'd15, 2);
            submit(8'd1, 0, 0, INPUT, 0);
        end
        chk("miss_sat", MISS_CNT, 15);
        expect_v(2'b00, 2'b11, 4'd15, 3);
        submit(8'd7, 0, 2, QUESTION, 0);

        repeat (3) @(posedge CLK);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
